// File: rtl/exp_taylor.sv
// ============================================================================
// exp_taylor : pipelined fixed-point e^x, one Taylor term added per stage
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module exp_taylor #(
  parameter int N_STAGE   = 6,
  parameter int FRAC_BITS = 12
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_data_tdata,
  input  logic        s_axis_data_tvalid,
  output logic        s_axis_data_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready
);

  localparam logic signed [63:0] ONE   = 64'sd1 <<< FRAC_BITS;
  localparam logic signed [63:0] MAX32 = 64'sd2147483647;
  localparam logic signed [63:0] MIN32 = -64'sd2147483648;

  // Reciprocal factorials floor(2^FRAC_BITS / k!), resolved at elaboration.
  function automatic logic [N_STAGE:0][31:0] rcp_table();
    logic [N_STAGE:0][31:0] tab;
    logic [63:0]            fact;
    tab  = '0;
    fact = 64'd1;
    for (int k = 1; k <= N_STAGE; k++) begin
      fact   = fact * 64'(k);
      tab[k] = 32'((64'd1 << FRAC_BITS) / fact);
    end
    return tab;
  endfunction

  localparam logic [N_STAGE:0][31:0] RCP = rcp_table();

  function automatic logic signed [63:0] sx64(input logic [31:0] a);
    return $signed({{32{a[31]}}, a});
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [63:0] val);
    if (val > MAX32)
      return 32'sh7FFF_FFFF;
    else if (val < MIN32)
      return 32'sh8000_0000;
    else
      return val[31:0];
  endfunction

  function automatic logic signed [31:0] next_power(input logic [31:0] p_in,
                                                    input logic [31:0] x_in);
    logic signed [63:0] prod;
    prod = sx64(p_in) * sx64(x_in);
    return sat32(prod >>> FRAC_BITS);
  endfunction

  function automatic logic signed [31:0] add_term(input logic [31:0] acc_in,
                                                  input logic [31:0] t_in,
                                                  input logic [31:0] rcp_in,
                                                  input logic        clamp);
    logic signed [63:0] term;
    logic signed [31:0] sum;
    term = (sx64(t_in) * sx64(rcp_in)) >>> FRAC_BITS;
    sum  = sat32(sx64(acc_in) + term);
    if (clamp && sum < 0)
      sum = '0;
    return sum;
  endfunction

  // x and x^k are never consumed past stage N_STAGE-1, so only the
  // accumulator and valid bit exist in the final stage.
  logic               v     [1:N_STAGE];
  logic signed [31:0] xr    [1:N_STAGE-1];
  logic signed [31:0] p     [1:N_STAGE-1];
  logic signed [31:0] acc   [1:N_STAGE];
  logic signed [31:0] t_n   [2:N_STAGE];
  logic signed [31:0] acc_n [2:N_STAGE];
  logic               en;

  assign en                 = !v[N_STAGE] || m_axis_data_tready;
  assign s_axis_data_tready = en;
  assign m_axis_data_tdata  = acc[N_STAGE];
  assign m_axis_data_tvalid = v[N_STAGE];

  always_comb begin
    for (int k = 2; k <= N_STAGE; k++) begin
      t_n[k]   = '0;
      acc_n[k] = '0;
    end
    for (int k = 2; k <= N_STAGE; k++) begin
      t_n[k]   = next_power(p[k-1], xr[k-1]);
      acc_n[k] = add_term(acc[k-1], t_n[k], RCP[k], k == N_STAGE);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int k = 1; k <= N_STAGE; k++) begin
        v[k]   <= 1'b0;
        acc[k] <= '0;
      end
      for (int k = 1; k < N_STAGE; k++) begin
        xr[k] <= '0;
        p[k]  <= '0;
      end
    end else if (en) begin
      v[1] <= s_axis_data_tvalid;
      if (s_axis_data_tvalid) begin
        xr[1]  <= s_axis_data_tdata;
        p[1]   <= s_axis_data_tdata;
        acc[1] <= sat32(ONE + sx64(s_axis_data_tdata));
      end
      for (int k = 2; k <= N_STAGE; k++) begin
        v[k]   <= v[k-1];
        acc[k] <= acc_n[k];
      end
      for (int k = 2; k < N_STAGE; k++) begin
        xr[k] <= xr[k-1];
        p[k]  <= t_n[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/exp_taylor.md
Name: exp_taylor

Overview:
- Pipelined fixed-point e^x evaluator using the Taylor series centred at 0: e^x = sum over k of x^k/k!.
- It is the inverse-function companion of the team's pipelined ln(x) Taylor block, used by the HSS datapath to map log-domain values back to linear domain.
- One Taylor term is added per pipeline stage, with full AXI-Stream handshaking on both sides, including backpressure.

Parameters:
- N_STAGE, 6: number of pipeline stages; series is summed through the x^N_STAGE term; legal range 2..10.
- FRAC_BITS, 12: fractional bits of the signed 32-bit fixed-point format used on input, output and internally; ONE = 2^FRAC_BITS.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset.
- s_axis_data_tdata  in  32  signed x, Q(31-FRAC_BITS).FRAC_BITS.
- s_axis_data_tvalid  in  1  input valid.
- s_axis_data_tready  out  1  input ready.
- m_axis_data_tdata  out  32  signed e^x, same Q format, never negative.
- m_axis_data_tvalid  out  1  output valid.
- m_axis_data_tready  in  1  downstream ready.

Behaviour:
- Reset: aresetn is a synchronous, active-low reset; clock is aclk. While aresetn=0 at a rising edge, the block clears all stage valid bits, all stage data registers, m_axis_data_tdata (0) and m_axis_data_tvalid (0). s_axis_data_tready is combinational and reads 1 during and after reset, since the pipeline is empty.
- Coefficients: RCP[k] = floor(2^FRAC_BITS / k!) for k=2..N_STAGE, computed at elaboration by a constant function. There is no memory file. Example, FRAC_BITS=12: RCP[2]=2048, RCP[3]=682, RCP[4]=170, RCP[5]=34, RCP[6]=5.
- Advance enable: en = !v[N_STAGE] || m_axis_data_tready, where v[k] is the stage-k valid bit. s_axis_data_tready = en. No register changes while en=0, so the whole pipeline stalls and holds.
- Stage 1, on an edge with en=1:
  - v1 <= s_tvalid.
  - If s_tvalid: X1 <= x, P1 <= x, A1 <= sat32(ONE + x).
- Stage k = 2..N_STAGE, on an edge with en=1:
  - v_k <= v_{k-1}; X_k <= X_{k-1}.
  - t = sat32((P_{k-1} * X_{k-1}) >>> FRAC_BITS), formed from a 64-bit signed product; P_k <= t.
  - A_k <= sat32(A_{k-1} + ((t * RCP[k]) >>> FRAC_BITS)), 64-bit product, arithmetic shift.
  - In the last stage, A is clamped: if the result is negative, store 0.
- Data registers of invalid stages may update freely; only v bits are qualified.
- sat32: clamps to 0x7FFFFFFF / 0x80000000.
- Output:
  - m_axis_data_tdata = A_N_STAGE.
  - m_axis_data_tvalid = v_N_STAGE.
  - Both stay stable while tvalid=1 and tready=0, as required by AXI-Stream.
- Latency: a beat accepted at edge t appears on the output after edge t+N_STAGE-1, i.e. N_STAGE register stages. Throughput is 1 beat/clock when m_tready=1.
- Simultaneous events:
  - A beat can be accepted in the same cycle another is consumed at the output.
  - Bubbles (s_tvalid=0) propagate as v=0 and do not block. A bubble in the last stage keeps en=1 even with m_tready=0.
- Reset mid-operation: in-flight beats are discarded. No output beat is produced for them after reset release.
- No range reduction is performed. Accuracy degrades for |x| > 2.0; that is the caller's responsibility. Overflow saturates rather than wraps.

Test Plan:
- Reset/idle, N_STAGE=6, FRAC_BITS=12: hold aresetn=0 for 3 clocks, then release -> m_tvalid=0, m_tdata=0, s_tready=1 throughout.
- Single beats: x=0 -> exactly 4096 after 6 edges. x=4096 (1.0) -> within ±8 LSB of 11133. x=-4096 -> within ±8 of 1508. x=2048 (0.5) -> within ±8 of 6753. Every beat must bit-exactly match a bench model of the stage equations above.
- Streaming and bubbles: x=-8192..8192 in steps of 512, s_tvalid toggled pseudo-randomly, m_tready=1 -> outputs in order, one per accepted input, bit-exact with the model, no duplicates or drops.
- Backpressure: fill the pipeline with m_tready=0 -> s_tready falls when v6=1, and m_tdata/m_tvalid hold for 10 clocks. Raise m_tready -> 6 results drain in order, one per clock. A bubble in stage 6 with m_tready=0 must still accept input.
- Saturation/clamp: x=0x7FFFFFFF -> m_tdata=0x7FFFFFFF, with no wrap to negative. x=-16384 (-4.0) -> m_tdata ≥ 0, clamped to 0 if the series goes negative.
- Reset mid-stream: with 4 beats in flight, assert aresetn=0 for 1 clock -> m_tvalid=0 on the next edge, and no stale beat appears afterwards. A beat issued after release emerges with 6-cycle latency and the correct value.
